// File: rtl/plru_tree.sv
// Tree pseudo-LRU replacement state for SETS independent sets of WAYS ways.
// Optional macro PLRU_INVALID_FIRST_EN: prefer the lowest-index invalid way as victim.
module plru_tree #(
  parameter int  WAYS  = 4,
  parameter int  SETS  = 4,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             access_valid,
  input  logic [SET_W-1:0] access_set,
  input  logic [WAY_W-1:0] access_way,
  input  logic             evict_req,
  input  logic [SET_W-1:0] evict_set,
  input  logic [WAYS-1:0]  way_valid,
  output logic             evict_valid,
  output logic [WAY_W-1:0] evict_way
);

  logic [SETS-1:0][WAYS-2:0] tree_q, tree_d;
  logic                      evict_valid_q, evict_valid_d;
  logic [WAY_W-1:0]          evict_way_q, evict_way_d;

  logic             acc_in_range, ev_in_range;
  logic             acc_ok, ev_ok;
  logic [WAYS-1:0]  vict_tree;
  logic [WAY_W-1:0] victim;

  // Trees are handled padded to WAYS bits so node indices fit in WAY_W bits.
  function automatic logic [WAY_W-1:0] walk(input logic [WAYS-1:0] t);
    logic [WAY_W-1:0] nd;
    logic [WAY_W-1:0] w;
    nd = '0;
    w  = '0;
    for (int d = 0; d < WAY_W; d++) begin
      w  = {w[WAY_W-1:0], t[nd]} >> 0;
      nd = WAY_W'(2 * int'(nd) + 1 + int'(t[nd]));
    end
    return w;
  endfunction

  function automatic logic [WAYS-1:0] touch(input logic [WAYS-1:0] t,
                                            input logic [WAY_W-1:0] w);
    logic [WAYS-1:0]  r;
    logic [WAY_W-1:0] ww;
    logic [WAY_W-1:0] nd;
    r  = t;
    ww = w;
    nd = '0;
    for (int d = 0; d < WAY_W; d++) begin
      r[nd] = ~ww[WAY_W-1];
      nd    = WAY_W'(2 * int'(nd) + 1 + int'(ww[WAY_W-1]));
      ww    = ww << 1;
    end
    return r;
  endfunction

  if (SETS == (1 << SET_W)) begin : g_pow2
    assign acc_in_range = 1'b1;
    assign ev_in_range  = 1'b1;
  end else begin : g_npow2
    assign acc_in_range = (access_set < SET_W'(SETS));
    assign ev_in_range  = (evict_set < SET_W'(SETS));
  end

  assign acc_ok = access_valid && acc_in_range;
  assign ev_ok  = evict_req && ev_in_range && !flush;

`ifndef PLRU_INVALID_FIRST_EN
  logic unused_way_valid;
  assign unused_way_valid = ^way_valid;
`endif

  always_comb begin
    vict_tree = '0;
    for (int s = 0; s < SETS; s++) begin
      if (evict_set == SET_W'(s)) vict_tree = {1'b0, tree_q[s]};
    end
    victim = walk(vict_tree);
`ifdef PLRU_INVALID_FIRST_EN
    if (~way_valid != '0) begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (!way_valid[i]) victim = WAY_W'(i);
      end
    end
`endif
  end

  // Same-set collision: the fill-touch is applied on top of the access touch.
  always_comb begin
    logic [WAYS-1:0] t;
    tree_d = tree_q;
    t      = '0;
    for (int s = 0; s < SETS; s++) begin
      t = {1'b0, tree_q[s]};
      if (acc_ok && access_set == SET_W'(s)) t = touch(t, access_way);
      if (ev_ok && evict_set == SET_W'(s))   t = touch(t, victim);
      tree_d[s] = t[WAYS-2:0];
    end
    if (flush) tree_d = '0;
    evict_valid_d = ev_ok;
    evict_way_d   = ev_ok ? victim : evict_way_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree_q        <= '0;
      evict_valid_q <= 1'b0;
      evict_way_q   <= '0;
    end else begin
      tree_q        <= tree_d;
      evict_valid_q <= evict_valid_d;
      evict_way_q   <= evict_way_d;
    end
  end

  assign evict_valid = evict_valid_q;
  assign evict_way   = evict_way_q;

endmodule

// File: tb/tb_plru_tree.sv
// Directed-vector bench for plru_tree (WAYS=4, SETS=4); honours PLRU_INVALID_FIRST_EN.
module tb_plru_tree;

  logic       clk = 1'b0;
  logic       rst, flush, access_valid, evict_req;
  logic [1:0] access_set, access_way, evict_set;
  logic [3:0] way_valid;
  logic       evict_valid;
  logic [1:0] evict_way;

  int n_vec = 0;
  int n_bad = 0;

  plru_tree #(.WAYS(4), .SETS(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .access_valid(access_valid), .access_set(access_set), .access_way(access_way),
    .evict_req(evict_req), .evict_set(evict_set), .way_valid(way_valid),
    .evict_valid(evict_valid), .evict_way(evict_way)
  );

  always #5 clk = ~clk;

`ifdef PLRU_INVALID_FIRST_EN
  localparam logic [1:0] X_IF1 = 2'd2;
  localparam logic [1:0] X_IF2 = 2'd3;
`else
  localparam logic [1:0] X_IF1 = 2'd0;
  localparam logic [1:0] X_IF2 = 2'd0;
`endif

  typedef struct {
    logic       fl;
    logic       av;
    logic [1:0] as;
    logic [1:0] aw;
    logic       ev;
    logic [1:0] es;
    logic [3:0] wv;
    logic       xv;
    logic [1:0] xw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic fl, logic av, logic [1:0] as, logic [1:0] aw,
                              logic ev, logic [1:0] es, logic [3:0] wv,
                              logic xv, logic [1:0] xw);
    vec_t v;
    v.fl = fl; v.av = av; v.as = as; v.aw = aw;
    v.ev = ev; v.es = es; v.wv = wv; v.xv = xv; v.xw = xw;
    return v;
  endfunction

  task automatic drive(input logic r, input vec_t v);
    @(negedge clk);
    rst = r; flush = v.fl;
    access_valid = v.av; access_set = v.as; access_way = v.aw;
    evict_req = v.ev; evict_set = v.es; way_valid = v.wv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic xv, input logic [1:0] xw);
    n_vec++;
    if (evict_valid !== xv || evict_way !== xw) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b way=%0d, want valid=%0b way=%0d",
               name, evict_valid, evict_way, xv, xw);
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 4'hf, 0, 0);
    rst = 1'b1; flush = 1'b0; access_valid = 1'b0; access_set = '0; access_way = '0;
    evict_req = 1'b0; evict_set = '0; way_valid = 4'hf;

    // LRU order, then walk the full eviction cycle of set 0
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'hf, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'hf, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0, 0, 4'hf, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 0, 0, 4'hf, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'hf, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'hf, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'hf, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'hf, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hf, 0, 3));
    // single touch in set 1 alongside evict of set 0
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 4'hf, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 4'hf, 1, 2));
    // flush, then same-set collision
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'hf, 0, 2));
    tbl.push_back(mk(0, 1, 0, 3, 1, 0, 4'hf, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'hf, 1, 2));
    // invalid-first
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 4'b1011, 1, X_IF1));
    // fill every set, then flush with a colliding evict
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 4'hf, 0, X_IF1));
    tbl.push_back(mk(0, 1, 1, 2, 0, 0, 4'hf, 0, X_IF1));
    tbl.push_back(mk(0, 1, 2, 3, 0, 0, 4'hf, 0, X_IF1));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 4'hf, 0, X_IF1));
    tbl.push_back(mk(1, 1, 3, 0, 1, 1, 4'hf, 0, X_IF1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 4'hf, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 4'hf, 1, 0));
    // access and evict to different sets
    tbl.push_back(mk(0, 1, 2, 1, 1, 3, 4'hf, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 4'hf, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 4'hf, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hf, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 4'b0111, 1, X_IF2));

    drive(1'b1, idle);
    drive(1'b1, idle);
    check("reset", 1'b0, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b0, tbl[i]);
      check($sformatf("vec%0d", i), tbl[i].xv, tbl[i].xw);
    end

    // reset arriving right after a served evict drops the next request too
    drive(1'b0, mk(0, 0, 0, 0, 1, 1, 4'hf, 0, 0));
    check("pre_rst_evict", 1'b1, 2'd2);
    drive(1'b1, mk(0, 1, 2, 2, 1, 1, 4'hf, 0, 0));
    check("mid_rst", 1'b0, 2'd0);
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, mk(0, 0, 0, 0, 1, 2'(s), 4'hf, 0, 0));
      check($sformatf("post_rst_set%0d", s), 1'b1, 2'd0);
    end
    drive(1'b0, idle);
    check("post_rst_idle", 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
